// File: rtl/sensor_debounce.sv
// Sensor synchroniser and per-channel debouncer with a shared change strobe.
// Optional rejected-glitch counter: define DEBOUNCE_GLITCH_CNT_EN.
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       H1_raw,
  input  logic       H2_raw,
  input  logic       B1_raw,
  input  logic       B2_raw,
  output logic       H1,
  output logic       H2,
  output logic       B1,
  output logic       B2,
`ifdef DEBOUNCE_GLITCH_CNT_EN
  output logic [7:0] Glitch_cnt,
`endif
  output logic       Changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       raw;
  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       db;
  logic [3:0]       pend;
  logic [3:0]       accept;
  logic [CNT_W-1:0] cnt [4];

  assign raw = {B2_raw, B1_raw, H2_raw, H1_raw};
  assign H1  = db[0];
  assign H2  = db[1];
  assign B1  = db[2];
  assign B2  = db[3];

  always_comb begin
    pend   = '0;
    accept = '0;
    for (int i = 0; i < 4; i++) begin
      pend[i]   = s2[i] != db[i];
      accept[i] = pend[i] && (cnt[i] == LAST);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1      <= '0;
      s2      <= '0;
      db      <= '0;
      Changed <= 1'b0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      db      <= db ^ accept;
      Changed <= |accept;
      for (int i = 0; i < 4; i++) begin
        if (pend[i] && !accept[i]) cnt[i] <= cnt[i] + 1'b1;
        else                       cnt[i] <= '0;
      end
    end
  end

`ifdef DEBOUNCE_GLITCH_CNT_EN
  logic [3:0] glitch;
  logic [2:0] gsum;
  logic [8:0] gnext;

  // A pending run that ends with s2 back at the output level was a glitch
  always_comb begin
    glitch = '0;
    for (int i = 0; i < 4; i++)
      glitch[i] = !pend[i] && (cnt[i] != '0);
    gsum  = 3'($countones(glitch));
    gnext = {1'b0, Glitch_cnt} + {6'd0, gsum};
  end

  always_ff @(posedge Clk) begin
    if (Rst)           Glitch_cnt <= '0;
    else if (gnext[8]) Glitch_cnt <= 8'hFF;
    else               Glitch_cnt <= gnext[7:0];
  end
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: directed spec scenarios plus random stimulus
// checked every cycle against a run-length reference model.
module tb_sensor_debounce;

  localparam int D = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       H1_raw = 1'b0;
  logic       H2_raw = 1'b0;
  logic       B1_raw = 1'b0;
  logic       B2_raw = 1'b0;
  logic       H1, H2, B1, B2, Changed;
  logic [7:0] glitch_cnt;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  sensor_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .Clk(Clk),
    .Rst(Rst),
    .H1_raw(H1_raw),
    .H2_raw(H2_raw),
    .B1_raw(B1_raw),
    .B2_raw(B2_raw),
    .H1(H1),
    .H2(H2),
    .B1(B1),
    .B2(B2),
`ifdef DEBOUNCE_GLITCH_CNT_EN
    .Glitch_cnt(glitch_cnt),
`endif
    .Changed(Changed)
  );

`ifndef DEBOUNCE_GLITCH_CNT_EN
  assign glitch_cnt = 8'd0;
`endif

  always #5 Clk = ~Clk;

  // Reference: raw delayed two edges, then output flips once the synced
  // level has disagreed with it for D consecutive edges.
  bit ms1 [4];
  bit ms2 [4];
  bit mout [4];
  int run [4];
  bit mchg;
  int mgc;

  task automatic model_step();
    bit r [4];
    int nacc;
    int ng;
    r[0] = H1_raw; r[1] = H2_raw; r[2] = B1_raw; r[3] = B2_raw;
    nacc = 0;
    ng = 0;
    if (Rst) begin
      for (int i = 0; i < 4; i++) begin
        ms1[i] = 0; ms2[i] = 0; mout[i] = 0; run[i] = 0;
      end
      mchg = 0;
      mgc = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ms2[i] != mout[i]) begin
          if (run[i] + 1 == D) begin
            mout[i] = ~mout[i];
            run[i] = 0;
            nacc++;
          end else run[i]++;
        end else begin
          if (run[i] > 0) ng++;
          run[i] = 0;
        end
        ms2[i] = ms1[i];
        ms1[i] = r[i];
      end
      mchg = nacc > 0;
      mgc = (mgc + ng > 255) ? 255 : mgc + ng;
    end
  endtask

  initial forever begin
    @(posedge Clk);
    model_step();
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge Clk);
    if (chk_en) begin
      check("model_h1", int'(H1), int'(mout[0]));
      check("model_h2", int'(H2), int'(mout[1]));
      check("model_b1", int'(B1), int'(mout[2]));
      check("model_b2", int'(B2), int'(mout[3]));
      check("model_changed", int'(Changed), int'(mchg));
`ifdef DEBOUNCE_GLITCH_CNT_EN
      check("model_glitch", int'(glitch_cnt), mgc);
`endif
    end
  end

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_raw(input logic [3:0] v);
    {B2_raw, B1_raw, H2_raw, H1_raw} = v;
  endtask

  task automatic do_reset();
    set_raw(4'b0000);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  int n;
  int nchg;

  initial begin
    // 1: reset with all raw lines high
    @(negedge Clk);
    set_raw(4'b1111);
    Rst = 1'b1;
    tick();
    chk_en = 1'b1;
    check("rst_outs_a", int'({H1, H2, B1, B2}), 0);
    tick();
    check("rst_outs_b", int'({H1, H2, B1, B2}), 0);
    Rst = 1'b0;
    tick();
    check("post_rst_outs", int'({H1, H2, B1, B2}), 0);
    check("post_rst_chg", int'(Changed), 0);
    check("post_rst_glitch", int'(glitch_cnt), 0);

    // 2: H1 latency
    do_reset();
    H1_raw = 1'b1;
    n = 0;
    while (!H1 && n < 20) begin tick(); n++; end
    check("h1_latency", n, D + 2);
    check("h1_changed", int'(Changed), 1);
    check("h1_others", int'({H2, B1, B2}), 0);
    tick();
    check("h1_changed_drop", int'(Changed), 0);
    check("h1_hold", int'(H1), 1);

    // 3: short B2 pulse is rejected
    do_reset();
    B2_raw = 1'b1;
    nchg = 0;
    repeat (3) begin tick(); nchg += int'(Changed); end
    B2_raw = 1'b0;
    repeat (8) begin tick(); nchg += int'(Changed); end
    check("b2_glitch_out", int'(B2), 0);
    check("b2_glitch_nochg", nchg, 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("b2_glitch_cnt", int'(glitch_cnt), 1);
`endif

    // 4: all channels together
    do_reset();
    set_raw(4'b1111);
    n = 0;
    nchg = 0;
    while (!H1 && n < 20) begin tick(); n++; nchg += int'(Changed); end
    check("all_latency", n, D + 2);
    check("all_outs", int'({H1, H2, B1, B2}), 15);
    tick();
    nchg += int'(Changed);
    repeat (4) begin tick(); nchg += int'(Changed); end
    check("all_one_pulse", nchg, 1);

    // 5: reset mid-count on H2
    do_reset();
    H2_raw = 1'b1;
    repeat (2) tick();
    Rst = 1'b1;
    repeat (2) tick();
    check("h2_rst_out", int'(H2), 0);
    Rst = 1'b0;
    n = 0;
    while (!H2 && n < 20) begin tick(); n++; end
    check("h2_rst_latency", n, D + 2);

    // 6: repeated B1 glitches saturate the counter
    do_reset();
    repeat (300) begin
      B1_raw = 1'b1;
      repeat (2) tick();
      B1_raw = 1'b0;
      repeat (2) tick();
    end
    repeat (4) tick();
    check("b1_sat_out", int'(B1), 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
    check("b1_sat_cnt", int'(glitch_cnt), 255);
`endif

    // Random: per-channel flips and occasional reset
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(4) == 0) H1_raw = ~H1_raw;
      if ($urandom_range(4) == 0) H2_raw = ~H2_raw;
      if ($urandom_range(6) == 0) B1_raw = ~B1_raw;
      if ($urandom_range(2) == 0) B2_raw = ~B2_raw;
      Rst = ($urandom_range(150) == 0);
      tick();
    end
    Rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
